tlb_assoc: RTL and testbench

//   Parametrised fully-associative TLB translating virtual to physical addresses for the

---
 rtl/tlb_pkg.sv | 20 ++
 rtl/tlb_victim_sel.sv | 28 ++
 rtl/tlb_assoc.sv | 209 ++++++++++++++++++++
 tb/tb_tlb_assoc.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// Shared types and width helpers for the fully-associative TLB.
package tlb_pkg;

  // Lookup/fill FSM: normal operation, or sweeping valid bits clear.
  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } tlb_state_e;

  // Page-number width left once the untranslated offset is removed.
  function automatic int page_num_w(input int addr_w, input int offset_w);
    return addr_w - offset_w;
  endfunction

  // Bits needed to index DEPTH entries (at least one).
  function automatic int index_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/tlb_victim_sel.sv
// Fill-slot chooser: lowest-index invalid entry if any, otherwise the
// round-robin pointer entry, in which case the pointer advances (wrapping).
module tlb_victim_sel
  import tlb_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3
) (
  input  logic [DEPTH-1:0] valid_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] idx_o,
  output logic [IDX_W-1:0] next_ptr_o
);

  logic any_free;

  // Scan from the top so the lowest free index is the last one written.
  always_comb begin
    idx_o    = ptr_i;
    any_free = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      idx_o    = valid_i[i] ? idx_o : IDX_W'(i);
      any_free = any_free | ~valid_i[i];
    end
    next_ptr_o = any_free ? ptr_i : (ptr_i + IDX_W'(1'b1));
  end

endmodule

// File: rtl/tlb_assoc.sv
// Fully-associative TLB: valid/ready lookups with a registered one-cycle
// response, run-time fills with duplicate suppression and round-robin
// replacement, and a one-entry-per-cycle flush sweep.
// Optional build macro TLB_STATS_EN adds saturating hit/miss counters.
module tlb_assoc
  import tlb_pkg::*;
#(
  parameter int VA_W     = 32,
  parameter int PA_W     = 16,
  parameter int OFFSET_W = 6,
  parameter int DEPTH    = 8
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  lookup_valid,
  output logic                  lookup_ready,
  input  logic [VA_W-1:0]       lookup_va,
  output logic                  resp_valid,
  output logic                  resp_hit,
  output logic [PA_W-1:0]       resp_pa,
  input  logic                  fill_valid,
  output logic                  fill_ready,
  input  logic [VA_W-OFFSET_W-1:0] fill_vpn,
  input  logic [PA_W-OFFSET_W-1:0] fill_ppn,
  input  logic                  flush
`ifdef TLB_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int VPN_W = page_num_w(VA_W, OFFSET_W);
  localparam int PPN_W = page_num_w(PA_W, OFFSET_W);
  localparam int IDX_W = index_w(DEPTH);

  // Entry layout depends on the instance widths, so it is declared here.
  typedef struct packed {
    logic             valid;
    logic [VPN_W-1:0] vpn;
    logic [PPN_W-1:0] ppn;
  } entry_t;

  entry_t           entry_q [DEPTH];
  entry_t           entry_d [DEPTH];
  tlb_state_e       state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             resp_valid_q, resp_hit_q;
  logic [PA_W-1:0]  resp_pa_q;

  logic             run;
  logic             lookup_fire, fill_fire;
  logic [DEPTH-1:0] valid_vec;
  logic             lk_hit, fl_hit;
  logic [IDX_W-1:0] lk_idx, fl_idx, vict_idx, vict_next, fill_idx;

  // FSM state register and flush sweep index.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_RUN;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // FSM next state: enter FLUSH on flush in RUN, leave after the last entry.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      ST_RUN: begin
        if (flush) begin
          state_d = ST_FLUSH;
          sweep_d = '0;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (sweep_q == IDX_W'(DEPTH - 1)) begin
          state_d = ST_RUN;
          sweep_d = '0;
        end else begin
          sweep_d = sweep_q + IDX_W'(1'b1);
        end
      end
      default: begin
        state_d = ST_RUN;
        sweep_d = '0;
      end
    endcase
  end

  // FSM outputs: both request channels are accepted only while running.
  always_comb begin
    run          = (state_q == ST_RUN);
    lookup_ready = run;
    fill_ready   = run;
  end

  assign lookup_fire = lookup_valid & lookup_ready;
  assign fill_fire   = fill_valid & fill_ready;

  // Match vectors with lowest-index priority for lookup and for fill.
  always_comb begin
    lk_hit = 1'b0;
    lk_idx = '0;
    fl_hit = 1'b0;
    fl_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      valid_vec[i] = entry_q[i].valid;
      lk_idx = (entry_q[i].valid && entry_q[i].vpn == lookup_va[VA_W-1:OFFSET_W])
               ? IDX_W'(i) : lk_idx;
      lk_hit = lk_hit | (entry_q[i].valid && entry_q[i].vpn == lookup_va[VA_W-1:OFFSET_W]);
      fl_idx = (entry_q[i].valid && entry_q[i].vpn == fill_vpn) ? IDX_W'(i) : fl_idx;
      fl_hit = fl_hit | (entry_q[i].valid && entry_q[i].vpn == fill_vpn);
    end
  end

  tlb_victim_sel #(
    .DEPTH(DEPTH),
    .IDX_W(IDX_W)
  ) u_victim_sel (
    .valid_i   (valid_vec),
    .ptr_i     (ptr_q),
    .idx_o     (vict_idx),
    .next_ptr_o(vict_next)
  );

  // An existing vpn is overwritten in place and never moves the pointer.
  assign fill_idx = fl_hit ? fl_idx : vict_idx;
  assign ptr_d    = (fill_fire && !fl_hit) ? vict_next : ptr_q;

  // Entry next state: flush sweep clears one valid bit, fill writes one entry.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (state_q == ST_FLUSH && sweep_q == IDX_W'(i)) begin
        entry_d[i] = '{valid: 1'b0, vpn: entry_q[i].vpn, ppn: entry_q[i].ppn};
      end else if (fill_fire && fill_idx == IDX_W'(i)) begin
        entry_d[i] = '{valid: 1'b1, vpn: fill_vpn, ppn: fill_ppn};
      end else begin
        entry_d[i] = entry_q[i];
      end
    end
  end

  // Entry array and replacement pointer.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
      ptr_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= entry_d[i];
      end
      ptr_q <= ptr_d;
    end
  end

  // Response register: sees pre-fill contents; miss returns a zero address.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_pa_q    <= '0;
    end else begin
      resp_valid_q <= lookup_fire;
      resp_hit_q   <= lookup_fire & lk_hit;
      resp_pa_q    <= (lookup_fire && lk_hit)
                      ? {entry_q[lk_idx].ppn, lookup_va[OFFSET_W-1:0]} : '0;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_hit   = resp_hit_q;
  assign resp_pa    = resp_pa_q;

`ifdef TLB_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // Saturating hit/miss counters; only Resetn clears them, flush does not.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else begin
      if (resp_valid_q && resp_hit_q && hit_cnt_q != 32'hFFFF_FFFF) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end else begin
        hit_cnt_q <= hit_cnt_q;
      end
      if (resp_valid_q && !resp_hit_q && miss_cnt_q != 32'hFFFF_FFFF) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end else begin
        miss_cnt_q <= miss_cnt_q;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_tlb_assoc.sv
// Scoreboard bench for tlb_assoc: randomized and directed traffic, expected
// responses from a slot-table model, compared by an independent monitor.
module tb_tlb_assoc;

  localparam int DEPTH = 8;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        lookup_valid = 1'b0, lookup_ready;
  logic [31:0] lookup_va = '0;
  logic        resp_valid, resp_hit;
  logic [15:0] resp_pa;
  logic        fill_valid = 1'b0, fill_ready;
  logic [25:0] fill_vpn = '0;
  logic [9:0]  fill_ppn = '0;
  logic        flush = 1'b0;
`ifdef TLB_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  tlb_assoc dut (
    .Clock(Clock), .Resetn(Resetn),
    .lookup_valid(lookup_valid), .lookup_ready(lookup_ready), .lookup_va(lookup_va),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_pa(resp_pa),
    .fill_valid(fill_valid), .fill_ready(fill_ready),
    .fill_vpn(fill_vpn), .fill_ppn(fill_ppn), .flush(flush)
`ifdef TLB_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    int          stamp;
    bit          hit;
    logic [15:0] pa;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  int checks = 0, errors = 0;

  // Reference model: a table of slots plus a replacement pointer.
  bit          m_valid [DEPTH];
  logic [25:0] m_vpn   [DEPTH];
  logic [9:0]  m_ppn   [DEPTH];
  int          m_ptr;
  int          m_hits, m_misses;

  logic        last_hit;
  logic [15:0] last_pa;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void m_clear(input bit full_reset);
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    if (full_reset) begin
      m_ptr = 0;
      m_hits = 0;
      m_misses = 0;
    end
  endfunction

  function automatic void m_lookup(input logic [31:0] va, output bit hit, output logic [15:0] pa);
    hit = 1'b0;
    pa  = 16'h0000;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_valid[i] && m_vpn[i] == va[31:6]) begin
        hit = 1'b1;
        pa  = {m_ppn[i], va[5:0]};
        break;
      end
    end
  endfunction

  function automatic void m_fill(input logic [25:0] vpn, input logic [9:0] ppn);
    for (int i = 0; i < DEPTH; i++) begin
      if (m_valid[i] && m_vpn[i] == vpn) begin
        m_ppn[i] = ppn;
        return;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (!m_valid[i]) begin
        m_valid[i] = 1'b1; m_vpn[i] = vpn; m_ppn[i] = ppn;
        return;
      end
    end
    m_valid[m_ptr] = 1'b1; m_vpn[m_ptr] = vpn; m_ppn[m_ptr] = ppn;
    m_ptr = (m_ptr + 1) % DEPTH;
  endfunction

  // Monitor: every response must match the oldest expectation, one cycle late.
  always @(negedge Clock) begin
    if (Resetn) begin
      if (resp_valid) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_resp: got resp_valid=1 expected none (cycle %0d)", cyc);
        end else begin
          mon_e = sbq.pop_front();
          chk("resp_latency", cyc, mon_e.stamp + 1);
          chk("resp_hit", {31'd0, resp_hit}, {31'd0, mon_e.hit});
          chk("resp_pa", {16'd0, resp_pa}, {16'd0, mon_e.pa});
          if (mon_e.hit) m_hits++; else m_misses++;
        end
        last_hit = resp_hit;
        last_pa  = resp_pa;
      end else if (sbq.size() != 0 && cyc > sbq[0].stamp + 1) begin
        checks++; errors++;
        $display("FAIL missing_resp: got no response expected one for cycle %0d", sbq[0].stamp);
        void'(sbq.pop_front());
      end
    end
  end

  // One clock of stimulus; the model follows whatever the DUT accepts.
  task automatic step(input bit lv, input logic [31:0] va, input bit fv,
                      input logic [25:0] vpn, input logic [9:0] ppn, input bit fl);
    exp_t e;
    @(negedge Clock);
    lookup_valid = lv; lookup_va = va;
    fill_valid = fv; fill_vpn = vpn; fill_ppn = ppn; flush = fl;
    #1;
    chk("fill_ready_eq_lookup_ready", {31'd0, fill_ready}, {31'd0, lookup_ready});
    if (lv && lookup_ready) begin
      e.stamp = cyc;
      m_lookup(va, e.hit, e.pa);
      sbq.push_back(e);
    end
    if (fv && fill_ready) m_fill(vpn, ppn);
    if (fl && lookup_ready) m_clear(1'b0);
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 26'h0, 10'h0, 1'b0);
  endtask

  task automatic look(input logic [31:0] va);
    last_hit = 1'bx;
    last_pa  = 16'hxxxx;
    step(1'b1, va, 1'b0, 26'h0, 10'h0, 1'b0);
    idle();
  endtask

  task automatic fill(input logic [25:0] vpn, input logic [9:0] ppn);
    step(1'b0, 32'h0, 1'b1, vpn, ppn, 1'b0);
  endtask

  task automatic expect_last(input string name, input logic hit, input logic [15:0] pa);
    chk({name, "_hit"}, {31'd0, last_hit}, {31'd0, hit});
    chk({name, "_pa"}, {16'd0, last_pa}, {16'd0, pa});
  endtask

  // Asynchronous reset landing mid-cycle; any in-flight response is dropped.
  task automatic reset_dut();
    @(posedge Clock);
    #2;
    Resetn = 1'b0;
    lookup_valid = 1'b0; fill_valid = 1'b0; flush = 1'b0;
    @(negedge Clock);
    #1;
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_hit", {31'd0, resp_hit}, 32'd0);
    chk("rst_resp_pa", {16'd0, resp_pa}, 32'd0);
    chk("rst_lookup_ready", {31'd0, lookup_ready}, 32'd1);
`ifdef TLB_STATS_EN
    chk("rst_hit_count", hit_count, 32'd0);
    chk("rst_miss_count", miss_count, 32'd0);
`endif
    sbq.delete();
    m_clear(1'b1);
    #2;
    Resetn = 1'b1;
  endtask

  function automatic logic [25:0] rvpn();
    logic [25:0] v;
    v = 26'($urandom_range(0, 11));
    if ($urandom_range(0, 3) == 0) v[25] = 1'b1;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int low;
    m_clear(1'b1);
    reset_dut();

    // Miss right after reset.
    look(32'h0000_0045);
    expect_last("miss_after_reset", 1'b0, 16'h0000);

    // Basic translation.
    fill(26'd1, 10'h12C);
    look(32'h0000_0047);
    expect_last("hit_vpn1", 1'b1, 16'h4B07);

    // Nine fills into eight entries: vpn 8 evicts entry 0 (vpn 0).
    reset_dut();
    for (int v = 0; v <= 8; v++) fill(26'(v), 10'(v + 16'h100));
    look(32'h0000_0003);
    expect_last("evicted_vpn0", 1'b0, 16'h0000);
    for (int v = 1; v <= 8; v++) look({26'(v), 6'h0A});
    expect_last("kept_vpn8", 1'b1, {10'h108, 6'h0A});

    // Duplicate vpn overwrites in place, no eviction of the others.
    reset_dut();
    fill(26'd3, 10'd5);
    fill(26'd3, 10'd9);
    for (int v = 10; v <= 16; v++) fill(26'(v), 10'(v));
    look({26'd3, 6'h05});
    expect_last("dup_vpn3", 1'b1, 16'h0245);
    for (int v = 10; v <= 16; v++) look({26'(v), 6'h01});

    // Same-cycle lookup and fill of one vpn: miss, then hit.
    last_hit = 1'bx;
    step(1'b1, {26'd20, 6'h11}, 1'b1, 26'd20, 10'h3A, 1'b0);
    idle();
    expect_last("same_cycle_miss", 1'b0, 16'h0000);
    look({26'd20, 6'h11});
    expect_last("next_cycle_hit", 1'b1, 16'hE91);

    // Flush with a full table; lookup issued as flush is seen completes on old contents.
    last_hit = 1'bx;
    step(1'b1, {26'd20, 6'h11}, 1'b0, 26'h0, 10'h0, 1'b1);
    low = 0;
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 32'h0, 1'b0, 26'h0, 10'h0, k < 4);
      if (lookup_ready) break;
      low++;
    end
    chk("flush_ready_low_cycles", low, DEPTH);
    expect_last("lookup_at_flush", 1'b1, 16'hE91);
    look({26'd20, 6'h11});
    expect_last("after_flush_miss", 1'b0, 16'h0000);
    for (int v = 10; v <= 16; v++) look({26'(v), 6'h01});

    // Reset during a lookup: no response may appear.
    fill(26'd5, 10'd7);
    step(1'b1, {26'd5, 6'h03}, 1'b0, 26'h0, 10'h0, 1'b0);
    reset_dut();

    // Reset during a flush sweep: table empty, pipeline running again.
    fill(26'd6, 10'd2);
    step(1'b0, 32'h0, 1'b0, 26'h0, 10'h0, 1'b1);
    idle(); idle(); idle();
    reset_dut();
    look({26'd6, 6'h00});
    expect_last("after_mid_flush_reset", 1'b0, 16'h0000);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      step(1'($urandom_range(0, 1)), {rvpn(), 6'($urandom_range(0, 63))},
           1'($urandom_range(0, 1)), rvpn(), 10'($urandom_range(0, 1023)),
           $urandom_range(0, 39) == 0);
    end
    for (int n = 0; n < 12; n++) idle();
    chk("scoreboard_drained", sbq.size(), 32'd0);
`ifdef TLB_STATS_EN
    chk("hit_count", hit_count, m_hits);
    chk("miss_count", miss_count, m_misses);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
